// File: rtl/relay_seq_pkg.sv
// Shared types and defaults for the relay power-sequencing slice.
package relay_seq_pkg;

  typedef enum logic [2:0] {
    OFF       = 3'd0,
    DC_SETTLE = 3'd1,
    DC_ON     = 3'd2,
    AC_SETTLE = 3'd3,
    AC_ON     = 3'd4,
    AC_DROP   = 3'd5,
    DC_DROP   = 3'd6
  } relayState_t;

  localparam int unsigned SETTLE_CYCLES_DEF = 1000000;
  localparam int unsigned BLINK_CYCLES_DEF  = 2000000;

endpackage

// File: rtl/relay_sequencer_dwell_timer.sv
// Up-counter with synchronous clear; done flags the last count of a LIMIT-cycle window.
module dwell_timer #(
  parameter int unsigned LIMIT = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic done
);

  logic [CNT_W-1:0] countR;

  // Counter register: reset and clear both restart the window at zero
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      countR <= {CNT_W{1'b0}};
    end else begin
      countR <= countR + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign done = (countR == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/relay_sequencer.sv
// Orders DC/AC relay coil changes with a settle dwell per change and blinks the status LEDs in transit.
module relay_sequencer
  import relay_seq_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int unsigned BLINK_CYCLES  = BLINK_CYCLES_DEF,
  parameter int unsigned CNT_W         = 21
) (
  input  logic clk,
  input  logic rst,
  input  logic dc_on_req,
  input  logic dc_off_req,
  input  logic ac_on_req,
  input  logic ac_off_req,
  output logic relay_dc,
  output logic relay_ac,
  output logic led_dc,
  output logic led_ac,
  output logic busy
);

  relayState_t stateR, stateNext;
  logic acPendR, acPendNext, dcDownR, dcDownNext;
  logic blinkPhR, blinkPhNext;
  logic settleDone, blinkDone, settleClr;
  logic relayDcNext, relayAcNext, ledDcNext, ledAcNext, busyNext;

  assign settleClr   = (stateNext != stateR);
  assign blinkPhNext = blinkDone ? ~blinkPhR : blinkPhR;

  dwell_timer #(.LIMIT(SETTLE_CYCLES), .CNT_W(CNT_W)) uSettle (
    .clk(clk), .rst(rst), .clr(settleClr), .done(settleDone)
  );

  dwell_timer #(.LIMIT(BLINK_CYCLES), .CNT_W(CNT_W)) uBlink (
    .clk(clk), .rst(rst), .clr(blinkDone), .done(blinkDone)
  );

  // State, flags and registered outputs; outputs follow the state being entered
  always_ff @(posedge clk) begin
    if (rst) begin
      stateR   <= OFF;
      acPendR  <= 1'b0;
      dcDownR  <= 1'b0;
      blinkPhR <= 1'b0;
      relay_dc <= 1'b0;
      relay_ac <= 1'b0;
      led_dc   <= 1'b0;
      led_ac   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      stateR   <= stateNext;
      acPendR  <= acPendNext;
      dcDownR  <= dcDownNext;
      blinkPhR <= blinkPhNext;
      relay_dc <= relayDcNext;
      relay_ac <= relayAcNext;
      led_dc   <= ledDcNext;
      led_ac   <= ledAcNext;
      busy     <= busyNext;
    end
  end

  // Next-state logic; requests are taken in priority order dc_off > ac_off > ac_on > dc_on
  always_comb begin
    stateNext  = stateR;
    acPendNext = acPendR;
    dcDownNext = dcDownR;
    case (stateR)
      OFF: begin
        if (ac_on_req) begin
          stateNext  = DC_SETTLE;
          acPendNext = 1'b1;
        end else if (dc_on_req) begin
          stateNext = DC_SETTLE;
        end else begin
          stateNext = OFF;
        end
      end
      DC_SETTLE: begin
        if (dc_off_req) begin
          stateNext  = DC_DROP;
          acPendNext = 1'b0;
        end else begin
          if (ac_off_req) begin
            acPendNext = 1'b0;
          end else if (ac_on_req) begin
            acPendNext = 1'b1;
          end else begin
            acPendNext = acPendR;
          end
          // A request landing on the expiry cycle still decides where we go
          if (settleDone) begin
            stateNext  = acPendNext ? AC_SETTLE : DC_ON;
            acPendNext = 1'b0;
          end else begin
            stateNext = DC_SETTLE;
          end
        end
      end
      DC_ON: begin
        if (dc_off_req) begin
          stateNext = DC_DROP;
        end else if (ac_on_req) begin
          stateNext = AC_SETTLE;
        end else begin
          stateNext = DC_ON;
        end
      end
      AC_SETTLE, AC_ON: begin
        if (dc_off_req) begin
          stateNext  = AC_DROP;
          dcDownNext = 1'b1;
        end else if (ac_off_req) begin
          stateNext = AC_DROP;
        end else if ((stateR == AC_SETTLE) && settleDone) begin
          stateNext = AC_ON;
        end else begin
          stateNext = stateR;
        end
      end
      AC_DROP: begin
        if (dc_off_req) begin
          dcDownNext = 1'b1;
        end else begin
          dcDownNext = dcDownR;
        end
        if (settleDone) begin
          stateNext  = dcDownNext ? DC_DROP : DC_ON;
          dcDownNext = 1'b0;
        end else begin
          stateNext = AC_DROP;
        end
      end
      DC_DROP: begin
        if (settleDone) begin
          stateNext = OFF;
        end else begin
          stateNext = DC_DROP;
        end
      end
      default: begin
        stateNext  = OFF;
        acPendNext = 1'b0;
        dcDownNext = 1'b0;
      end
    endcase
  end

  // Output decode of the state being entered, so the registers line up with it
  always_comb begin
    relayDcNext = 1'b0;
    relayAcNext = 1'b0;
    ledDcNext   = 1'b0;
    ledAcNext   = 1'b0;
    busyNext    = 1'b0;
    case (stateNext)
      OFF: begin
        busyNext = 1'b0;
      end
      DC_SETTLE: begin
        relayDcNext = 1'b1;
        ledDcNext   = blinkPhNext;
        busyNext    = 1'b1;
      end
      DC_ON: begin
        relayDcNext = 1'b1;
        ledDcNext   = 1'b1;
      end
      AC_SETTLE: begin
        relayDcNext = 1'b1;
        relayAcNext = 1'b1;
        ledDcNext   = 1'b1;
        ledAcNext   = blinkPhNext;
        busyNext    = 1'b1;
      end
      AC_ON: begin
        relayDcNext = 1'b1;
        relayAcNext = 1'b1;
        ledDcNext   = 1'b1;
        ledAcNext   = 1'b1;
      end
      AC_DROP: begin
        relayDcNext = 1'b1;
        ledDcNext   = 1'b1;
        ledAcNext   = blinkPhNext;
        busyNext    = 1'b1;
      end
      DC_DROP: begin
        ledDcNext = blinkPhNext;
        busyNext  = 1'b1;
      end
      default: begin
        busyNext = 1'b0;
      end
    endcase
  end

endmodule
